// File: rtl/opicorv32_pcpi_issue_if.sv
// PCPI bus between the issuing core and the attached coprocessors.
// master = issuing core, slave = coprocessor.
interface opicorv32_pcpi_issue_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/opicorv32_pcpi_issue.sv
// Core-side PCPI issue unit: takes one offload request, presents it on the
// PCPI bus, waits for a coprocessor to finish (pcpi_wait keeps it alive) and
// returns the result, or an illegal-instruction trap if nobody claims the
// instruction within TIMEOUT cycles.
// Optional macro PCPI_ISSUE_STATS_EN adds issue/timeout statistics counters;
// without it the stat ports read as zero and no counter flops exist.
module opicorv32_pcpi_issue #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_trap,
  opicorv32_pcpi_issue_if.master pcpi,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_timeouts
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  count;
  logic        req_ready_q;
  logic        pcpi_valid_q;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        rsp_valid_q;
  logic        rsp_wr_q;
  logic [31:0] rsp_rd_q;
  logic        rsp_trap_q;

  logic accept;
  logic take_rsp;
  logic time_out;

  assign accept   = (state == IDLE) && req_valid && !kill;
  assign take_rsp = (state == BUSY) && !kill && pcpi.pcpi_ready;
  assign time_out = (state == BUSY) && !kill && !pcpi.pcpi_ready &&
                    !pcpi.pcpi_wait && (count == 8'd1);

  // Issue FSM: accept, hold the PCPI request until ready or timeout, then
  // present the captured response for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      req_ready_q  <= 1'b1;
      pcpi_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_wr_q     <= 1'b0;
      rsp_rd_q     <= '0;
      rsp_trap_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            insn_q       <= req_insn;
            rs1_q        <= req_rs1;
            rs2_q        <= req_rs2;
            count        <= TimeoutLoad;
            req_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (kill) begin
            pcpi_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end else if (take_rsp) begin
            pcpi_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_wr_q     <= pcpi.pcpi_wr;
            rsp_rd_q     <= pcpi.pcpi_wr ? pcpi.pcpi_rd : 32'd0;
            rsp_trap_q   <= 1'b0;
            state        <= RESP;
          end else if (pcpi.pcpi_wait) begin
            count <= TimeoutLoad;
          end else if (time_out) begin
            pcpi_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_wr_q     <= 1'b0;
            rsp_rd_q     <= '0;
            rsp_trap_q   <= 1'b1;
            state        <= RESP;
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_wr_q    <= 1'b0;
          rsp_rd_q    <= '0;
          rsp_trap_q  <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          pcpi_valid_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  // The response strobe is registered, but a flush arriving during the RESP
  // cycle itself must still cancel it, hence the gating with kill here.
  assign rsp_valid = rsp_valid_q && !kill;
  assign rsp_wr    = rsp_valid && rsp_wr_q;
  assign rsp_rd    = rsp_valid ? rsp_rd_q : 32'd0;
  assign rsp_trap  = rsp_valid && rsp_trap_q;

  assign req_ready       = req_ready_q;
  assign pcpi.pcpi_valid = pcpi_valid_q;
  assign pcpi.pcpi_insn  = insn_q;
  assign pcpi.pcpi_rs1   = rs1_q;
  assign pcpi.pcpi_rs2   = rs2_q;

`ifdef PCPI_ISSUE_STATS_EN
  logic [31:0] issued_q;
  logic [31:0] timeouts_q;

  // Free-running statistics: accepted requests and trap responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q   <= '0;
      timeouts_q <= '0;
    end else begin
      if (accept)   issued_q   <= issued_q + 32'd1;
      if (time_out) timeouts_q <= timeouts_q + 32'd1;
    end
  end

  assign stat_issued   = issued_q;
  assign stat_timeouts = timeouts_q;
`else
  assign stat_issued   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_opicorv32_pcpi_issue.sv
// Self-checking bench for opicorv32_pcpi_issue (TIMEOUT=16). A vector table
// drives complete transactions; expected responses go into a scoreboard
// queue and are checked by a monitor when rsp_valid appears. Kill, reset
// and IDLE-side corner cases are hand-written sequences.
module tb_opicorv32_pcpi_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        kill = 1'b0;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_trap;
  logic [31:0] stat_issued;
  logic [31:0] stat_timeouts;

  opicorv32_pcpi_issue_if pcpi();

  opicorv32_pcpi_issue #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_insn      (req_insn),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .kill          (kill),
    .rsp_valid     (rsp_valid),
    .rsp_wr        (rsp_wr),
    .rsp_rd        (rsp_rd),
    .rsp_trap      (rsp_trap),
    .pcpi          (pcpi.master),
    .stat_issued   (stat_issued),
    .stat_timeouts (stat_timeouts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          wait_cycles;
    int          ready_cycle;
    logic        p_wr;
    logic [31:0] p_rd;
    logic        exp_wr;
    logic [31:0] exp_rd;
    logic        exp_trap;
    int          exp_resp;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        trap;
    int          cycle;
  } sb_t;

  vec_t vecs [8];
  sb_t  sb [$];

  int cur_cycle = 0;
  int n_compared = 0;
  int n_mismatched = 0;
  int exp_issued = 0;
  int exp_timeouts = 0;

  always @(posedge clk) cur_cycle <= cur_cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cur_cycle);
    end
  endtask

  task automatic checkStats();
`ifdef PCPI_ISSUE_STATS_EN
    checkOutput("stat_issued", stat_issued, 32'(exp_issued));
    checkOutput("stat_timeouts", stat_timeouts, 32'(exp_timeouts));
`else
    checkOutput("stat_issued", stat_issued, 32'd0);
    checkOutput("stat_timeouts", stat_timeouts, 32'd0);
`endif
  endtask

  task automatic idleBus();
    pcpi.pcpi_wait  = 1'b0;
    pcpi.pcpi_ready = 1'b0;
    pcpi.pcpi_wr    = 1'b0;
    pcpi.pcpi_rd    = '0;
  endtask

  task automatic driveReq(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
  endtask

  // Scoreboard monitor: each rsp_valid pops one expected response.
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with no response expected (cycle %0d)", cur_cycle);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_wr", 32'(rsp_wr), 32'(e.wr));
          checkOutput("rsp_rd", rsp_rd, e.rd);
          checkOutput("rsp_trap", 32'(rsp_trap), 32'(e.trap));
          checkOutput("rsp_cycle", 32'(cur_cycle), 32'(e.cycle));
        end
      end else begin
        checkOutput("rsp_idle_zero", rsp_rd | 32'(rsp_wr) | 32'(rsp_trap), 32'd0);
      end
    end
  end

  // One full transaction from a vector; call between negedge and posedge.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    int  accept_cycle;
    #1;
    driveReq(v.insn, v.rs1, v.rs2);
    accept_cycle = cur_cycle;
    e.wr    = v.exp_wr;
    e.rd    = v.exp_rd;
    e.trap  = v.exp_trap;
    e.cycle = accept_cycle + v.exp_resp;
    sb.push_back(e);
    exp_issued++;
    if (v.exp_trap) exp_timeouts++;
    for (int c = 1; c <= v.exp_resp + 1; c++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      pcpi.pcpi_wait = (c <= v.wait_cycles);
      if (c == v.ready_cycle) begin
        pcpi.pcpi_ready = 1'b1;
        pcpi.pcpi_wr    = v.p_wr;
        pcpi.pcpi_rd    = v.p_rd;
      end else begin
        pcpi.pcpi_ready = 1'b0;
        pcpi.pcpi_wr    = 1'($urandom_range(0, 1));
        pcpi.pcpi_rd    = $urandom;
      end
      @(negedge clk);
      checkOutput("pcpi_valid", 32'(pcpi.pcpi_valid), 32'(c < v.exp_resp));
      checkOutput("req_ready", 32'(req_ready), 32'(c > v.exp_resp));
      if (c == 1) begin
        checkOutput("pcpi_insn", pcpi.pcpi_insn, v.insn);
        checkOutput("pcpi_rs1", pcpi.pcpi_rs1, v.rs1);
        checkOutput("pcpi_rs2", pcpi.pcpi_rs2, v.rs2);
      end
    end
    idleBus();
    checkOutput("rsp_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    checkStats();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           insn          rs1           rs2           wait ready p_wr p_rd          exp_wr exp_rd       trap resp
    vecs[0] = '{32'h02B50533, 32'd7,        32'd6,        34,  35,   1'b1, 32'd42,       1'b1, 32'd42,       1'b0, 36};
    vecs[1] = '{32'h0000000B, 32'h11111111, 32'h22222222, 0,   0,    1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 17};
    vecs[2] = '{32'h02C5C5B3, 32'd3,        32'd4,        0,   16,   1'b1, 32'h55,       1'b1, 32'h55,       1'b0, 17};
    vecs[3] = '{32'h02D6C633, 32'd9,        32'd1,        0,   1,    1'b0, 32'hDEADBEEF, 1'b0, 32'd0,        1'b0, 2};
    vecs[4] = '{32'h0000100B, 32'd5,        32'd5,        0,   17,   1'b1, 32'hCAFE0001, 1'b0, 32'd0,        1'b1, 17};
    vecs[5] = '{32'h0000200B, 32'hA5A5A5A5, 32'h5A5A5A5A, 5,   0,    1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 22};
    vecs[6] = '{32'h02E7D6B3, 32'hFFFFFFFF, 32'd2,        2,   3,    1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 4};
    vecs[7] = '{32'h02F7E733, 32'd100,      32'd200,      4,   4,    1'b1, 32'h00ABCDEF, 1'b1, 32'h00ABCDEF, 1'b0, 5};

    idleBus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_pcpi_valid", 32'(pcpi.pcpi_valid), 32'd0);
    checkOutput("reset_pcpi_insn", pcpi.pcpi_insn, 32'd0);
    checkOutput("reset_pcpi_rs1", pcpi.pcpi_rs1, 32'd0);
    checkOutput("reset_pcpi_rs2", pcpi.pcpi_rs2, 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkStats();
    reset = 1'b0;

    // Table vectors back to back: each request is offered in the IDLE
    // cycle that follows the previous response.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Kill on BUSY cycle 3, then a normal request completes.
    #1;
    driveReq(32'h0000300B, 32'd1, 32'd2);
    exp_issued++;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      kill = (c == 3);
      @(negedge clk);
      if (c <= 3) begin
        checkOutput("kill_busy_valid", 32'(pcpi.pcpi_valid), 32'd1);
      end else begin
        checkOutput("kill_busy_dropped", 32'(pcpi.pcpi_valid), 32'd0);
        checkOutput("kill_busy_ready", 32'(req_ready), 32'd1);
      end
    end
    checkStats();
    applyStimulus(vecs[3]);

    // Kill during the RESP cycle suppresses the response strobe.
    #1;
    driveReq(32'h0000400B, 32'd3, 32'd3);
    exp_issued++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pcpi.pcpi_ready = 1'b1;
    pcpi.pcpi_wr    = 1'b1;
    pcpi.pcpi_rd    = 32'h77;
    @(posedge clk);
    #1;
    idleBus();
    kill = 1'b1;
    @(negedge clk);
    checkOutput("kill_resp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    checkOutput("kill_resp_ready", 32'(req_ready), 32'd1);
    checkOutput("kill_resp_pcpi_valid", 32'(pcpi.pcpi_valid), 32'd0);
    checkStats();

    // kill together with req_valid in IDLE: nothing is accepted.
    #1;
    driveReq(32'h0000500B, 32'd0, 32'd0);
    kill = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    kill = 1'b0;
    @(negedge clk);
    checkOutput("kill_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("kill_idle_pcpi_valid", 32'(pcpi.pcpi_valid), 32'd0);
    checkStats();

    // Reset asserted mid-BUSY.
    #1;
    driveReq(32'h0000600B, 32'h0BADF00D, 32'h0000FACE);
    exp_issued++;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (c == 3) reset = 1'b1;
    end
    @(posedge clk);
    exp_issued = 0;
    exp_timeouts = 0;
    @(negedge clk);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_pcpi_valid", 32'(pcpi.pcpi_valid), 32'd0);
    checkOutput("rst_mid_pcpi_insn", pcpi.pcpi_insn, 32'd0);
    checkOutput("rst_mid_pcpi_rs1", pcpi.pcpi_rs1, 32'd0);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_rsp_rd", rsp_rd, 32'd0);
    checkStats();
    reset = 1'b0;

    applyStimulus(vecs[1]);
    applyStimulus(vecs[6]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
